dl_lock_sched: RTL and testbench
================================

Name: dl_lock_sched

Overview:
- Scheduler for a bank of dynamic-locking lockboxes (dl instances), one per MZI.
- Shares the single calibration-pulse readback stream between them: each enabled lockbox gets a lock slot in turn.
- In its slot, a lockbox has trig_lock held and the calibration-valid signal routed to it. The slot ends when the lockbox reports done or a timeout fires.
- Sits between the GPIO config bus, the calibration pulse generator's readback flag, and the dl instances.

Parameters:
NUM_LOCKS, 4, number of dl instances scheduled (1..16)
base_addr, 0, GPIO register base address
CNT_W, 32, width of period/timeout/stat counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
gpio_in  in  32  config bus: [31] write strobe, [30:16] address, [15:0] data
cal_valid  in  1  high while the ADC stream carries a calibration pulse readback
lock_done  in  NUM_LOCKS  per-dl done flag (1 = not locking)
trig_lock  out  NUM_LOCKS  per-dl lock enable
lock_sig_active  out  NUM_LOCKS  cal_valid routed to the selected dl only
cur_idx  out  4  index currently being serviced
sched_busy  out  1  high in any state other than IDLE/WAIT_PERIOD
round_done  out  1  one-cycle pulse when a full round completes
timeout_flags  out  NUM_LOCKS  sticky per-dl timeout flag

Behaviour:
- Reset (async): all outputs 0; all config registers 0; FSM in IDLE.
- GPIO write strobe:
  - gpio_in[31] passes through a 2-flop synchronizer. Its rising edge latches the write.
  - The write takes effect 3 cycles after the strobe rises.
  - Registers: base+0 enable mask [NUM_LOCKS-1:0]; base+1 period[15:0]; base+2 period[31:16]; base+3 timeout[15:0] (cycles); base+4 start_delay[15:0]; base+5 control: bit0 run, bit1 clear timeout_flags (self-clearing).
  - Other addresses are ignored.
- FSM:
  - IDLE: run=1 and mask!=0 -> WAIT_PERIOD, counter loaded with period.
  - WAIT_PERIOD: count down. At 0 -> SELECT with idx=0.
  - SELECT: find the lowest enabled idx >= current idx, combinationally in one cycle. Found -> START. None -> round_done pulse, then WAIT_PERIOD (run=1) or IDLE (run=0).
  - START: trig_lock[idx]=1. Wait for lock_done[idx]=0, up to start_delay+16 cycles. Seen -> RUN with timeout counter loaded. Not seen -> set timeout_flags[idx], go to NEXT.
  - RUN: trig_lock[idx]=1 and lock_sig_active[idx]=cal_valid (registered, 1-cycle latency).
    - lock_done[idx]=1 -> NEXT.
    - Timeout counter reaching 0 -> set timeout_flags[idx], go to NEXT.
    - timeout=0 means no timeout.
  - NEXT: drop trig_lock and lock_sig_active for one cycle; idx+1; -> SELECT.
- At most one bit of trig_lock and of lock_sig_active is set at any time. Non-selected bits are 0.
- run cleared mid-round: the current slot finishes normally; the FSM then returns to IDLE instead of starting the next slot.
- Mask changed mid-round: takes effect at the next SELECT.
- Period of 0 means back-to-back rounds: WAIT_PERIOD lasts 1 cycle.
- Timeout-clear write coinciding with a new timeout: the set wins.
- Reset mid-slot: trig_lock drops asynchronously.

Optional Feature:
- Macro: DL_SCHED_STATS_EN.
- Defined:
  - Adds output last_lock_cycles [CNT_W-1:0]: cycles spent in RUN by the most recently completed slot, updated in NEXT.
  - Adds output rounds_cnt [CNT_W-1:0]: increments on round_done and wraps.
  - Both reset to 0.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Decomposition:
- Shared package ising_config: register offset constants (DL_SCHED_MASK_OFF..DL_SCHED_CTRL_OFF), the state enum typedef dl_sched_state_t, and the START grace constant (16).
- Sub-module gpio_reg_if: strobe synchronizer, edge detect and address decode. It is natural to reuse it for dl.

Test Plan:
1. mask=4'b0101, period=100, timeout=0, run=1; lock_done deasserts 2 cycles after trig and reasserts after 50 cycles -> trig_lock goes 0001, then 0100; cur_idx 0 then 2; round_done pulses once; second round starts 101 cycles later.
2. cal_valid toggling during idx=2 slot -> lock_sig_active[2] equals cal_valid delayed 1 cycle; other bits stay 0.
3. timeout=20, lock_done[1] stuck 0 -> slot ends 20 cycles after RUN entry; timeout_flags=0010; scheduler advances to the next idx; write control bit1 -> flags return to 0.
4. lock_done[3] stuck 1, start_delay=4 -> START times out after 20 cycles; timeout_flags[3]=1; no RUN entry.
5. Clear run during the idx=0 slot -> slot completes; FSM reaches IDLE; no further trig_lock. Assert rst mid-RUN -> all outputs 0 in the same cycle.
6. With DL_SCHED_STATS_EN, a 50-cycle RUN -> last_lock_cycles=50 and rounds_cnt increments per round_done.

Source files
------------

// File: rtl/dl_lock_sched_pkg.sv
// ---------------------------------------------------------------------------
// ising_config
// Shared constants and types for the dynamic-locking lockbox scheduler.
//   - GPIO register offsets, relative to the scheduler base address
//   - scheduler FSM state encoding
//   - fixed grace period added to start_delay while waiting in START
// ---------------------------------------------------------------------------
package ising_config;

    localparam int DL_SCHED_MASK_OFF   = 0;  // enable mask
    localparam int DL_SCHED_PER_LO_OFF = 1;  // period[15:0]
    localparam int DL_SCHED_PER_HI_OFF = 2;  // period[31:16]
    localparam int DL_SCHED_TMO_OFF    = 3;  // RUN timeout, 0 = none
    localparam int DL_SCHED_SDLY_OFF   = 4;  // start_delay
    localparam int DL_SCHED_CTRL_OFF   = 5;  // bit0 run, bit1 clear flags
    localparam int DL_SCHED_NUM_REGS   = 6;

    localparam int DL_SCHED_START_GRACE = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_PERIOD,
        S_SELECT,
        S_START,
        S_RUN,
        S_NEXT
    } dl_sched_state_t;

endpackage

// File: rtl/dl_lock_sched_gpio_reg_if.sv
// ---------------------------------------------------------------------------
// gpio_reg_if
// GPIO config-bus front end: synchronizes the write strobe, detects its
// rising edge and decodes the address into one write-select per register.
// Ports:
//   clk, rst   system clock, async active-high reset
//   gpio_in    [31] strobe, [30:16] address, [15:0] data
//   wr_sel     one-hot write select, bit k = register base_addr+k
//   wr_data    data field of the bus
// ---------------------------------------------------------------------------
module gpio_reg_if
    import ising_config::*;
#(
    parameter int base_addr = 0,
    parameter int NUM_REGS  = DL_SCHED_NUM_REGS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         gpio_in,
    output logic [NUM_REGS-1:0] wr_sel,
    output logic [15:0]         wr_data
);

    logic [2:0]  strobe_sync;
    logic        wr_edge;
    logic [14:0] addr;
    logic [14:0] base;
    logic [14:0] offset;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_sync <= '0;
        end else begin
            strobe_sync <= {strobe_sync[1:0], gpio_in[31]};
        end
    end

    // Address and data are taken straight from the bus: the host holds them
    // stable while the strobe is high, long past the synchronizer delay.
    assign wr_edge = strobe_sync[1] & ~strobe_sync[2];
    assign addr    = gpio_in[30:16];
    assign base    = 15'(base_addr);
    assign offset  = addr - base;
    assign wr_data = gpio_in[15:0];

    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_edge && (addr >= base) && (offset == 15'(k))) begin
                wr_sel[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dl_lock_sched.sv
// ---------------------------------------------------------------------------
// dl_lock_sched
// Round-robin scheduler giving each enabled dl lockbox an exclusive lock
// slot on the shared calibration-pulse readback stream.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   IDLE        | stopped; waits for run=1 with a non-empty mask
//   WAIT_PERIOD | counting down the inter-round period
//   SELECT      | pick lowest enabled index >= idx, or end the round
//   START       | trig_lock held, waiting for lock_done to drop
//   RUN         | dl locking; cal_valid routed; optional timeout running
//   NEXT        | one dead cycle between slots, idx advances
//
// Ports:
//   clk, rst         system clock, async active-high reset
//   gpio_in          config bus ([31] strobe, [30:16] addr, [15:0] data)
//   cal_valid        calibration-pulse readback flag
//   lock_done        per-dl done flag (1 = not locking)
//   trig_lock        per-dl lock enable (one-hot or zero)
//   lock_sig_active  cal_valid routed to the serviced dl (one-hot or zero)
//   cur_idx          index being serviced
//   sched_busy       high outside IDLE/WAIT_PERIOD
//   round_done       one-cycle pulse at the end of each round
//   timeout_flags    sticky per-dl timeout flags
// Optional, with DL_SCHED_STATS_EN defined:
//   last_lock_cycles RUN cycles of the most recently completed slot
//   rounds_cnt       wrapping count of completed rounds
// ---------------------------------------------------------------------------
module dl_lock_sched
    import ising_config::*;
#(
    parameter int NUM_LOCKS = 4,
    parameter int base_addr = 0,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          gpio_in,
    input  logic                 cal_valid,
    input  logic [NUM_LOCKS-1:0] lock_done,
    output logic [NUM_LOCKS-1:0] trig_lock,
    output logic [NUM_LOCKS-1:0] lock_sig_active,
    output logic [3:0]           cur_idx,
    output logic                 sched_busy,
    output logic                 round_done,
    output logic [NUM_LOCKS-1:0] timeout_flags
`ifdef DL_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0]     last_lock_cycles,
    output logic [CNT_W-1:0]     rounds_cnt
`endif
);

    logic [DL_SCHED_NUM_REGS-1:0] wr_sel;
    logic [15:0]                  wr_data;

    logic [NUM_LOCKS-1:0] mask;
    logic [15:0]          period_lo;
    logic [15:0]          period_hi;
    logic [15:0]          timeout_cyc;
    logic [15:0]          start_delay;
    logic                 run;
    logic                 clr_flags;

    dl_sched_state_t      state;
    logic [4:0]           idx;
    logic [NUM_LOCKS-1:0] sel;
    logic [CNT_W-1:0]     cnt;

    logic                 found;
    logic [4:0]           found_idx;
    logic [NUM_LOCKS-1:0] found_oh;
    logic [NUM_LOCKS-1:0] flags_base;
    logic [CNT_W-1:0]     period_cnt;
    logic [CNT_W-1:0]     start_lim;
    logic                 sel_done;

    gpio_reg_if #(
        .base_addr (base_addr),
        .NUM_REGS  (DL_SCHED_NUM_REGS)
    ) u_gpio (
        .clk     (clk),
        .rst     (rst),
        .gpio_in (gpio_in),
        .wr_sel  (wr_sel),
        .wr_data (wr_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask        <= '0;
            period_lo   <= '0;
            period_hi   <= '0;
            timeout_cyc <= '0;
            start_delay <= '0;
            run         <= 1'b0;
        end else begin
            if (wr_sel[DL_SCHED_MASK_OFF])   mask        <= wr_data[NUM_LOCKS-1:0];
            if (wr_sel[DL_SCHED_PER_LO_OFF]) period_lo   <= wr_data;
            if (wr_sel[DL_SCHED_PER_HI_OFF]) period_hi   <= wr_data;
            if (wr_sel[DL_SCHED_TMO_OFF])    timeout_cyc <= wr_data;
            if (wr_sel[DL_SCHED_SDLY_OFF])   start_delay <= wr_data;
            if (wr_sel[DL_SCHED_CTRL_OFF])   run         <= wr_data[0];
        end
    end

    // Clear is a pulse on the write itself; nothing is stored.
    assign clr_flags  = wr_sel[DL_SCHED_CTRL_OFF] & wr_data[1];
    assign flags_base = clr_flags ? '0 : timeout_flags;

    assign period_cnt = CNT_W'({period_hi, period_lo});
    assign start_lim  = CNT_W'(start_delay) + CNT_W'(DL_SCHED_START_GRACE);
    assign sel_done   = |(lock_done & sel);

    // Lowest enabled index at or above idx: scanning downwards leaves the
    // lowest match as the final assignment.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        found_oh  = '0;
        for (int i = NUM_LOCKS - 1; i >= 0; i--) begin
            if (mask[i] && (5'(i) >= idx)) begin
                found     = 1'b1;
                found_idx = 5'(i);
            end
        end
        for (int i = 0; i < NUM_LOCKS; i++) begin
            found_oh[i] = found && (found_idx == 5'(i));
        end
    end

    // Counter reaching 1 marks the last cycle of a START/RUN window; a
    // counter loaded with 0 parks at 0, which gives "timeout=0 never fires".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            idx             <= '0;
            sel             <= '0;
            cnt             <= '0;
            trig_lock       <= '0;
            lock_sig_active <= '0;
            cur_idx         <= '0;
            sched_busy      <= 1'b0;
            round_done      <= 1'b0;
            timeout_flags   <= '0;
        end else begin
            round_done    <= 1'b0;
            timeout_flags <= flags_base;
            case (state)
                S_IDLE: begin
                    if (run && (mask != '0)) begin
                        state <= S_WAIT_PERIOD;
                        cnt   <= period_cnt;
                    end
                end
                S_WAIT_PERIOD: begin
                    if (cnt == '0) begin
                        state      <= S_SELECT;
                        idx        <= '0;
                        sched_busy <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_SELECT: begin
                    if (!found) begin
                        round_done <= 1'b1;
                        sched_busy <= 1'b0;
                        if (run) begin
                            state <= S_WAIT_PERIOD;
                            cnt   <= period_cnt;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (!run) begin
                        state      <= S_IDLE;
                        sched_busy <= 1'b0;
                    end else begin
                        state     <= S_START;
                        idx       <= found_idx;
                        sel       <= found_oh;
                        cur_idx   <= found_idx[3:0];
                        trig_lock <= found_oh;
                        cnt       <= start_lim;
                    end
                end
                S_START: begin
                    if (!sel_done) begin
                        state <= S_RUN;
                        cnt   <= CNT_W'(timeout_cyc);
                    end else if (cnt == CNT_W'(1)) begin
                        state         <= S_NEXT;
                        trig_lock     <= '0;
                        timeout_flags <= flags_base | sel;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (sel_done) begin
                        state           <= S_NEXT;
                        trig_lock       <= '0;
                        lock_sig_active <= '0;
                    end else if (cnt == CNT_W'(1)) begin
                        state           <= S_NEXT;
                        trig_lock       <= '0;
                        lock_sig_active <= '0;
                        timeout_flags   <= flags_base | sel;
                    end else begin
                        lock_sig_active <= cal_valid ? sel : '0;
                        if (cnt != '0) cnt <= cnt - CNT_W'(1);
                    end
                end
                S_NEXT: begin
                    state <= S_SELECT;
                    idx   <= idx + 5'd1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DL_SCHED_STATS_EN
    logic [CNT_W-1:0] run_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cycles       <= '0;
            last_lock_cycles <= '0;
            rounds_cnt       <= '0;
        end else begin
            case (state)
                S_SELECT: run_cycles       <= '0;
                S_RUN:    run_cycles       <= run_cycles + CNT_W'(1);
                S_NEXT:   last_lock_cycles <= run_cycles;
                default:  ;
            endcase
            if (round_done) rounds_cnt <= rounds_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dl_lock_sched.sv
// ---------------------------------------------------------------------------
// tb_dl_lock_sched
// Directed bench for dl_lock_sched with NUM_LOCKS=4. A small per-lock dl
// model drives lock_done: mode 0 drops lock_done two cycles after trig_lock
// rises and raises it again after 50 cycles low; mode 1 holds it at 0;
// mode 2 holds it at 1.
// ---------------------------------------------------------------------------
module tb_dl_lock_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] gpio_in = '0;
    logic        cal_valid = 1'b0;
    logic [3:0]  lock_done = 4'hF;
    logic [3:0]  trig_lock;
    logic [3:0]  lock_sig_active;
    logic [3:0]  cur_idx;
    logic        sched_busy;
    logic        round_done;
    logic [3:0]  timeout_flags;
`ifdef DL_SCHED_STATS_EN
    logic [31:0] last_lock_cycles;
    logic [31:0] rounds_cnt;
`endif

    int tests = 0;
    int failures = 0;
    int mode [4] = '{0, 0, 0, 0};
    int on_cnt [4] = '{0, 0, 0, 0};

    typedef struct {
        logic       cal;
        logic [3:0] exp_lsa;
    } vec_t;
    vec_t vecs [10];

    dl_lock_sched #(
        .NUM_LOCKS (4),
        .base_addr (0),
        .CNT_W     (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .gpio_in         (gpio_in),
        .cal_valid       (cal_valid),
        .lock_done       (lock_done),
        .trig_lock       (trig_lock),
        .lock_sig_active (lock_sig_active),
        .cur_idx         (cur_idx),
        .sched_busy      (sched_busy),
        .round_done      (round_done),
        .timeout_flags   (timeout_flags)
`ifdef DL_SCHED_STATS_EN
        ,
        .last_lock_cycles(last_lock_cycles),
        .rounds_cnt      (rounds_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock, sample 1 ns later, then update the dl model.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (trig_lock[i]) on_cnt[i]++;
            else on_cnt[i] = 0;
            case (mode[i])
                0:       lock_done[i] = !(on_cnt[i] >= 2 && on_cnt[i] < 52);
                1:       lock_done[i] = 1'b0;
                default: lock_done[i] = 1'b1;
            endcase
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Register takes effect on the 3rd edge; strobe is then held low long
    // enough for the synchronizer to see the falling edge.
    task automatic wr(input logic [14:0] addr, input logic [15:0] data);
        gpio_in = {1'b1, addr, data};
        ticks(4);
        gpio_in[31] = 1'b0;
        ticks(3);
    endtask

    task automatic wait_trig(input string name, input logic [3:0] v, input int max);
        int n = 0;
        while (trig_lock !== v && n < max) begin
            tick();
            n++;
        end
        chk(name, trig_lock, v);
    endtask

    task automatic wait_round(input string name, input int max);
        int n = 0;
        while (round_done !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk(name, round_done, 1);
    endtask

    // Cycles for which trig_lock keeps value v; also counts cycles with any
    // lock_sig_active bit and any round_done pulse seen along the way.
    task automatic hold_len(input logic [3:0] v, input int max,
                            output int n, output int lsa_seen, output int rd_seen);
        n = 0; lsa_seen = 0; rd_seen = 0;
        while (trig_lock === v && n < max) begin
            tick();
            n++;
            if (lock_sig_active != 4'b0000) lsa_seen++;
            if (round_done) rd_seen++;
        end
    endtask

    initial begin
        int n, lsa_seen, rd_seen;

        vecs[0] = '{1'b1, 4'b0100};
        vecs[1] = '{1'b0, 4'b0000};
        vecs[2] = '{1'b1, 4'b0100};
        vecs[3] = '{1'b1, 4'b0100};
        vecs[4] = '{1'b0, 4'b0000};
        vecs[5] = '{1'b0, 4'b0000};
        vecs[6] = '{1'b1, 4'b0100};
        vecs[7] = '{1'b0, 4'b0000};
        vecs[8] = '{1'b1, 4'b0100};
        vecs[9] = '{1'b0, 4'b0000};

        ticks(3);
        rst = 1'b0;
        ticks(2);
        chk("reset trig_lock", trig_lock, 0);
        chk("reset lock_sig_active", lock_sig_active, 0);
        chk("reset cur_idx", cur_idx, 0);
        chk("reset sched_busy", sched_busy, 0);
        chk("reset round_done", round_done, 0);
        chk("reset timeout_flags", timeout_flags, 0);

        // Round with mask 0101, period 100, no timeout.
        wr(15'd0, 16'h0005);
        wr(15'd1, 16'd100);
        wr(15'd2, 16'd0);
        wr(15'd3, 16'd0);
        wr(15'd4, 16'd0);
        wr(15'd5, 16'h0001);
        chk("busy in wait_period", sched_busy, 0);
        wait_trig("first slot trig 0001", 4'b0001, 300);
        chk("first slot cur_idx", cur_idx, 0);
        chk("first slot busy", sched_busy, 1);
        // START 2 cycles (lock_done drops 2 cycles after trig) + RUN 50.
        hold_len(4'b0001, 200, n, lsa_seen, rd_seen);
        chk("slot0 trig length", n, 52);
        hold_len(4'b0000, 20, n, lsa_seen, rd_seen);
        chk("gap NEXT+SELECT", n, 2);
        chk("second slot trig 0100", trig_lock, 4'b0100);
        chk("second slot cur_idx", cur_idx, 2);
`ifdef DL_SCHED_STATS_EN
        chk("last_lock_cycles", last_lock_cycles, 50);
`endif

        // cal_valid routing during the idx=2 slot, one cycle of latency.
        ticks(3);
        for (int v = 0; v < 10; v++) begin
            cal_valid = vecs[v].cal;
            tick();
            chk($sformatf("lsa vec %0d", v), lock_sig_active, vecs[v].exp_lsa);
            chk($sformatf("trig vec %0d", v), trig_lock, 4'b0100);
        end
        cal_valid = 1'b0;

        wait_round("round_done pulse", 200);
        chk("round_done busy", sched_busy, 0);
        // WAIT_PERIOD lasts period+1 = 101 cycles, then SELECT, then START.
        hold_len(4'b0000, 300, n, lsa_seen, rd_seen);
        chk("round to round gap", n, 102);
        chk("single round_done", rd_seen, 0);
        chk("round 2 trig 0001", trig_lock, 4'b0001);
`ifdef DL_SCHED_STATS_EN
        chk("rounds_cnt after 1 round", rounds_cnt, 1);
`endif

        // Clear run mid-slot: slot completes, FSM parks in IDLE.
        wr(15'd5, 16'h0000);
        chk("slot survives run clear", trig_lock, 4'b0001);
        hold_len(4'b0001, 200, n, lsa_seen, rd_seen);
        chk("slot ends after run clear", trig_lock, 0);
        ticks(3);
        chk("idle busy after run clear", sched_busy, 0);
        hold_len(4'b0000, 150, n, lsa_seen, rd_seen);
        chk("no trig after run clear", n, 150);
        chk("no round_done after run clear", rd_seen, 0);

        // RUN timeout on lock 1, START timeout on lock 3.
        mode[1] = 1;
        mode[3] = 2;
        wr(15'd0, 16'h000A);
        wr(15'd3, 16'd20);
        wr(15'd4, 16'd4);
        wr(15'd5, 16'h0001);
        wait_trig("lock1 trig 0010", 4'b0010, 300);
        chk("lock1 cur_idx", cur_idx, 1);
        // 1 START cycle + 20 RUN cycles.
        hold_len(4'b0010, 100, n, lsa_seen, rd_seen);
        chk("lock1 slot length", n, 21);
        chk("lock1 timeout flag", timeout_flags, 4'b0010);
        hold_len(4'b0000, 20, n, lsa_seen, rd_seen);
        chk("gap to lock3", n, 2);
        chk("lock3 trig 1000", trig_lock, 4'b1000);
        chk("lock3 cur_idx", cur_idx, 3);
        cal_valid = 1'b1;
        // start_delay 4 + grace 16 = 20 cycles in START.
        hold_len(4'b1000, 100, n, lsa_seen, rd_seen);
        chk("lock3 start timeout length", n, 20);
        chk("lock3 never routed", lsa_seen, 0);
        chk("both timeout flags", timeout_flags, 4'b1010);
        cal_valid = 1'b0;
        wait_round("round_done after timeouts", 50);
        wr(15'd5, 16'h0002);
        chk("flags cleared", timeout_flags, 0);

        // Period 0 after reset, then async reset mid-RUN.
        rst = 1'b1;
        mode[1] = 0;
        mode[3] = 0;
        ticks(2);
        rst = 1'b0;
        ticks(2);
        wr(15'd0, 16'h0001);
        wr(15'd5, 16'h0001);
        wait_trig("p0 first trig", 4'b0001, 100);
        wait_round("p0 round_done", 200);
        // WAIT_PERIOD 1 cycle, SELECT 1 cycle.
        hold_len(4'b0000, 50, n, lsa_seen, rd_seen);
        chk("p0 back-to-back gap", n, 2);
        cal_valid = 1'b1;
        ticks(5);
        chk("p0 lsa before reset", lock_sig_active, 4'b0001);
        rst = 1'b1;
        #1;
        chk("async reset trig_lock", trig_lock, 0);
        chk("async reset lsa", lock_sig_active, 0);
        chk("async reset busy", sched_busy, 0);
        chk("async reset flags", timeout_flags, 0);
`ifdef DL_SCHED_STATS_EN
        chk("async reset rounds_cnt", rounds_cnt, 0);
        chk("async reset last_lock_cycles", last_lock_cycles, 0);
`endif
        cal_valid = 1'b0;
        ticks(2);
        rst = 1'b0;
        ticks(2);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
